// File: rtl/zap_fetch_ctrl.sv
// Instruction fetch controller: sequential PC, single-outstanding Wishbone-classic reads,
// 2-entry skid buffer toward the pre-decode FIFO. Define ZAP_FETCH_PERF_EN for the pop counter.
module zap_fetch_ctrl #(
  parameter int          WDT          = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0
) (
  input  logic           i_clk,
  input  logic           i_reset_n,
  input  logic           i_clear,
  input  logic [31:0]    i_clear_pc,
  output logic           o_instr_cyc,
  output logic           o_instr_stb,
  output logic [31:0]    o_instr_addr,
  input  logic           i_instr_ack,
  input  logic           i_instr_err,
  input  logic [WDT-1:0] i_instr_data,
  output logic [WDT-1:0] o_instr,
  output logic [31:0]    o_pc,
  output logic           o_abort,
  output logic           o_valid,
  input  logic           i_full,
  output logic [31:0]    o_fetch_count
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DISCARD} state_t;

  state_t         state, state_nxt;
  logic [31:0]    pc, pc_nxt;
  logic [31:0]    addr, addr_nxt;
  logic           stb, stb_nxt;
  logic [1:0]     occ, occ_nxt;
  logic [WDT-1:0] head_instr, tail_instr;
  logic [31:0]    head_pc, tail_pc;
  logic           head_abort, tail_abort;
  logic           done, push, pop, wr_head;
  logic [WDT-1:0] wr_instr;
  logic [31:0]    clear_pc;
  logic           unused_clear_bits;

  assign clear_pc          = {i_clear_pc[31:2], 2'b00};
  assign unused_clear_bits = &{1'b0, i_clear_pc[1:0]};

  assign done     = stb && (i_instr_ack || i_instr_err);
  assign o_valid  = (occ != 2'd0) && !i_clear;
  assign pop      = o_valid && !i_full;
  assign push     = (state == S_FETCH) && done && !i_clear;
  assign occ_nxt  = i_clear ? 2'd0 : (occ + {1'b0, push} - {1'b0, pop});
  assign wr_instr = i_instr_err ? '0 : i_instr_data;
  // New word lands in the head slot when the head is free (or being vacated this cycle)
  assign wr_head  = (occ == 2'd0) || ((occ == 2'd1) && pop);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= S_IDLE;
      pc    <= RESET_VECTOR;
      addr  <= 32'h0;
      stb   <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      addr  <= addr_nxt;
      stb   <= stb_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    addr_nxt  = addr;
    stb_nxt   = stb;
    case (state)
      S_IDLE: state_nxt = S_FETCH;
      S_FETCH: begin
        if (done)    pc_nxt = pc + 32'd4;
        if (i_clear) pc_nxt = clear_pc;
        if (stb && !done) begin
          // Read still in flight: a clear must wait out the bus cycle
          if (i_clear) state_nxt = S_DISCARD;
        end else if (occ_nxt < 2'd2) begin
          stb_nxt  = 1'b1;
          addr_nxt = pc_nxt;
        end else begin
          stb_nxt = 1'b0;
        end
      end
      S_DISCARD: begin
        if (i_clear) pc_nxt = clear_pc;
        if (done) begin
          stb_nxt   = 1'b0;
          state_nxt = S_FETCH;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      occ        <= 2'd0;
      head_instr <= '0;
      head_pc    <= 32'h0;
      head_abort <= 1'b0;
      tail_instr <= '0;
      tail_pc    <= 32'h0;
      tail_abort <= 1'b0;
    end else begin
      occ <= occ_nxt;
      if (pop) begin
        head_instr <= tail_instr;
        head_pc    <= tail_pc;
        head_abort <= tail_abort;
      end
      if (push) begin
        if (wr_head) begin
          head_instr <= wr_instr;
          head_pc    <= addr;
          head_abort <= i_instr_err;
        end else begin
          tail_instr <= wr_instr;
          tail_pc    <= addr;
          tail_abort <= i_instr_err;
        end
      end
    end
  end

  assign o_instr_cyc  = stb;
  assign o_instr_stb  = stb;
  assign o_instr_addr = addr;
  assign o_instr      = head_instr;
  assign o_pc         = head_pc;
  assign o_abort      = head_abort;

`ifdef ZAP_FETCH_PERF_EN
  logic [31:0] fetch_count;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)  fetch_count <= 32'h0;
    else if (pop)    fetch_count <= fetch_count + 32'd1;
  end

  assign o_fetch_count = fetch_count;
`else
  assign o_fetch_count = 32'h0;
`endif

endmodule

// File: tb/tb_zap_fetch_ctrl.sv
// Directed bench for zap_fetch_ctrl with a zero-wait instruction-bus responder.
module tb_zap_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic [31:0] clear_pc_in;
  logic        cyc, stb;
  logic [31:0] addr;
  logic        ack, err;
  logic [31:0] rdata;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        abort, valid, full;
  logic [31:0] fcount;

  logic        ack_en, err_en;
  logic [31:0] err_addr;
  int          cyc_n;
  int          passed = 0;
  int          total = 0;

  always #5 clk = ~clk;

  assign ack   = stb & ack_en;
  assign err   = stb & err_en & (addr == err_addr);
  assign rdata = addr ^ 32'hDEAD_0000;

  zap_fetch_ctrl dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_clear(clear), .i_clear_pc(clear_pc_in),
    .o_instr_cyc(cyc), .o_instr_stb(stb), .o_instr_addr(addr),
    .i_instr_ack(ack), .i_instr_err(err), .i_instr_data(rdata),
    .o_instr(instr), .o_pc(pc), .o_abort(abort), .o_valid(valid),
    .i_full(full), .o_fetch_count(fcount)
  );

  task automatic do_reset();
    rst_n = 1'b0; clear = 1'b0; clear_pc_in = 32'h0; full = 1'b0;
    ack_en = 1'b0; err_en = 1'b0; err_addr = 32'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc_n = 0;
  endtask

  task automatic wait_to(input int n);
    while (cyc_n < n) begin
      @(negedge clk);
      cyc_n++;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; clear_pc_in = 32'h0; full = 1'b0;
    ack_en = 1'b1; err_en = 1'b0; err_addr = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    total++; if (stb !== 1'b0) $display("FAIL rst_stb: got %b want 0", stb); else passed++;
    total++; if (cyc !== 1'b0) $display("FAIL rst_cyc: got %b want 0", cyc); else passed++;
    total++; if (valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", valid); else passed++;
    total++; if (instr !== 32'h0) $display("FAIL rst_instr: got %h want 0", instr); else passed++;
    total++; if (pc !== 32'h0) $display("FAIL rst_pc: got %h want 0", pc); else passed++;
    total++; if (abort !== 1'b0) $display("FAIL rst_abort: got %b want 0", abort); else passed++;
    total++; if (fcount !== 32'h0) $display("FAIL rst_count: got %h want 0", fcount); else passed++;
  endtask

  task automatic test_stream();
    do_reset();
    ack_en = 1'b1;
    wait_to(1);
    total++; if (stb !== 1'b0) $display("FAIL stream_idle_stb: got %b want 0", stb); else passed++;
    wait_to(2);
    total++; if (stb !== 1'b1 || addr !== 32'h0) $display("FAIL stream_first_req: got stb=%b addr=%h want 1/0", stb, addr); else passed++;
    total++; if (valid !== 1'b0) $display("FAIL stream_c2_valid: got %b want 0", valid); else passed++;
    for (int k = 3; k <= 10; k++) begin
      wait_to(k);
      total++;
      if (valid !== 1'b1 || pc !== 32'((k - 3) * 4) || instr !== (32'((k - 3) * 4) ^ 32'hDEAD_0000))
        $display("FAIL stream_c%0d: got v=%b pc=%h instr=%h want 1 pc=%h", k, valid, pc, instr, 32'((k - 3) * 4));
      else passed++;
      total++;
      if (stb !== 1'b1 || cyc !== 1'b1 || addr !== 32'((k - 2) * 4))
        $display("FAIL stream_addr_c%0d: got stb=%b cyc=%b addr=%h want 1/1/%h", k, stb, cyc, addr, 32'((k - 2) * 4));
      else passed++;
    end
  endtask

  task automatic test_full();
    int          nreads;
    logic [31:0] raddr [0:3];
    do_reset();
    ack_en = 1'b1; full = 1'b1;
    nreads = 0;
    for (int k = 1; k <= 12; k++) begin
      wait_to(k);
      if (stb && ack) begin
        if (nreads < 4) raddr[nreads] = addr;
        nreads++;
      end
    end
    total++; if (nreads !== 2) $display("FAIL full_reads: got %0d want 2", nreads); else passed++;
    total++; if (raddr[0] !== 32'h0 || raddr[1] !== 32'h4) $display("FAIL full_addrs: got %h %h want 0 4", raddr[0], raddr[1]); else passed++;
    total++; if (stb !== 1'b0) $display("FAIL full_stb_held: got %b want 0", stb); else passed++;
    full = 1'b0;
    #1;
    total++; if (valid !== 1'b1 || pc !== 32'h0) $display("FAIL full_rel_0: got v=%b pc=%h want 1 0", valid, pc); else passed++;
    wait_to(13);
    total++; if (valid !== 1'b1 || pc !== 32'h4) $display("FAIL full_rel_4: got v=%b pc=%h want 1 4", valid, pc); else passed++;
    total++; if (stb !== 1'b1 || addr !== 32'h8) $display("FAIL full_resume: got stb=%b addr=%h want 1 8", stb, addr); else passed++;
    wait_to(14);
    total++; if (valid !== 1'b1 || pc !== 32'h8) $display("FAIL full_rel_8: got v=%b pc=%h want 1 8", valid, pc); else passed++;
  endtask

  task automatic test_clear_discard();
    do_reset();
    ack_en = 1'b1;
    wait_to(10);
    ack_en = 1'b0;
    total++; if (stb !== 1'b1 || addr !== 32'h20) $display("FAIL disc_req20: got stb=%b addr=%h want 1 20", stb, addr); else passed++;
    wait_to(12);
    clear = 1'b1; clear_pc_in = 32'h103;
    #1;
    total++; if (valid !== 1'b0) $display("FAIL disc_clr_valid: got %b want 0", valid); else passed++;
    wait_to(13);
    clear = 1'b0; ack_en = 1'b1;
    #1;
    total++; if (stb !== 1'b1 || addr !== 32'h20) $display("FAIL disc_hold: got stb=%b addr=%h want 1 20", stb, addr); else passed++;
    wait_to(14);
    total++; if (stb !== 1'b0 || valid !== 1'b0) $display("FAIL disc_drop: got stb=%b v=%b want 0 0", stb, valid); else passed++;
    wait_to(15);
    total++; if (stb !== 1'b1 || addr !== 32'h100) $display("FAIL disc_newreq: got stb=%b addr=%h want 1 100", stb, addr); else passed++;
    total++; if (valid !== 1'b0) $display("FAIL disc_c15_valid: got %b want 0", valid); else passed++;
    wait_to(16);
    total++; if (valid !== 1'b1 || pc !== 32'h100 || instr !== 32'hDEAD_0100) $display("FAIL disc_first: got v=%b pc=%h instr=%h want 1 100 dead0100", valid, pc, instr); else passed++;
  endtask

  task automatic test_clear_ack();
    do_reset();
    ack_en = 1'b1;
    wait_to(18);
    total++; if (stb !== 1'b1 || addr !== 32'h40 || pc !== 32'h3C) $display("FAIL cack_setup: got stb=%b addr=%h pc=%h want 1 40 3c", stb, addr, pc); else passed++;
    clear = 1'b1; clear_pc_in = 32'h200;
    #1;
    total++; if (valid !== 1'b0) $display("FAIL cack_valid: got %b want 0", valid); else passed++;
    wait_to(19);
    clear = 1'b0;
    #1;
    total++; if (stb !== 1'b1 || addr !== 32'h200) $display("FAIL cack_newreq: got stb=%b addr=%h want 1 200", stb, addr); else passed++;
    total++; if (valid !== 1'b0) $display("FAIL cack_empty: got %b want 0", valid); else passed++;
    wait_to(20);
    total++; if (valid !== 1'b1 || pc !== 32'h200 || instr !== 32'hDEAD_0200) $display("FAIL cack_first: got v=%b pc=%h instr=%h want 1 200 dead0200", valid, pc, instr); else passed++;
  endtask

  task automatic test_err();
    do_reset();
    ack_en = 1'b1; err_en = 1'b1; err_addr = 32'h80;
    wait_to(35);
    total++; if (valid !== 1'b1 || pc !== 32'h80 || abort !== 1'b1 || instr !== 32'h0) $display("FAIL err_entry: got v=%b pc=%h abort=%b instr=%h want 1 80 1 0", valid, pc, abort, instr); else passed++;
    total++; if (stb !== 1'b1 || addr !== 32'h84) $display("FAIL err_next: got stb=%b addr=%h want 1 84", stb, addr); else passed++;
    wait_to(36);
    total++; if (valid !== 1'b1 || pc !== 32'h84 || abort !== 1'b0 || instr !== 32'hDEAD_0084) $display("FAIL err_after: got v=%b pc=%h abort=%b instr=%h want 1 84 0 dead0084", valid, pc, abort, instr); else passed++;
  endtask

  task automatic test_count();
    logic [31:0] exp_cnt;
`ifdef ZAP_FETCH_PERF_EN
    exp_cnt = 32'd37;
`else
    exp_cnt = 32'd0;
`endif
    do_reset();
    ack_en = 1'b1;
    wait_to(3);
    total++; if (fcount !== 32'h0) $display("FAIL cnt_start: got %0d want 0", fcount); else passed++;
    wait_to(40);
    clear = 1'b1; clear_pc_in = 32'h300; full = 1'b1; ack_en = 1'b0;
    #1;
    total++; if (fcount !== exp_cnt) $display("FAIL cnt_before_clr: got %0d want %0d", fcount, exp_cnt); else passed++;
    wait_to(41);
    clear = 1'b0;
    wait_to(43);
    total++; if (fcount !== exp_cnt) $display("FAIL cnt_after_clr: got %0d want %0d", fcount, exp_cnt); else passed++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_clear_discard();
    test_clear_ack();
    test_err();
    test_count();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
